sam_cfg_loader: RTL

SAM_CFG_LOADER -- requirements
Module: sam_cfg_loader

---
 rtl/sam_pkg.sv | 24 ++
 rtl/sam_shift_reg.sv | 30 +++
 rtl/sam_cfg_loader.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sam_pkg.sv
// Shared types and helpers for the SAM configuration loader.
// Optional feature macro: SAM_CFG_PARITY_EN (adds the CHECK state).
package sam_pkg;

  localparam int unsigned SAM_N_W_DEFAULT = 4;

  // Loader FSM states; CHECK exists only when the parity feature is built in
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_N  = 3'd1,
    LOAD_D  = 3'd2,
    LOAD_CN = 3'd3,
`ifdef SAM_CFG_PARITY_EN
    CHECK   = 3'd4,
`endif
    DONE    = 3'd5
  } sam_state_e;

  // Key length L = 2^n; out-of-range n yields 0 (caller range-checks n first)
  function automatic int unsigned sam_len_from_n(input int unsigned n);
    return (n < 32) ? (32'd1 << n) : 32'd0;
  endfunction

endpackage

// File: rtl/sam_shift_reg.sv
// MSB-first serial-in shadow register with synchronous clear.
// Clear together with shift-enable loads the incoming bit into a zeroed
// register, so a new load can start on the same edge that wipes old data.
module sam_shift_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_din,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Shift left, new bit enters at the LSB (right-justified result)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= i_en ? W'(i_din) : '0;
    end else if (i_en) begin
      r_q <= {r_q[W-2:0], i_din};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sam_cfg_loader.sv
// Serial loader for n, d and capsN key material with commit/abort handling.
// Build option: define SAM_CFG_PARITY_EN to append an even-parity bit that
// is checked in a CHECK state before commit. Requires N_W >= 2.
module sam_cfg_loader
  import sam_pkg::*;
#(
  parameter int unsigned KEY_W = 32,
  parameter int unsigned N_W   = SAM_N_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic                    str,
  output logic [N_W-1:0]          n_o,
  output logic [KEY_W-1:0]        d_o,
  output logic [KEY_W-1:0]        capsn_o,
  output logic [$clog2(KEY_W):0]  key_len_o,
  output logic                    cfg_valid,
  output logic                    cfg_err
);

  localparam int unsigned LOG2_KEY = $clog2(KEY_W);
  localparam int unsigned CNT_W    = LOG2_KEY + 1;
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_W - 1);

  sam_state_e       r_state;
  sam_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] w_len_new;

  logic             w_clr;
  logic             w_sh_n;
  logic             w_sh_d;
  logic             w_sh_c;
  logic             w_len_load;
  logic             w_commit;
  logic             w_err_set;
  logic             w_n_ok;
  logic             w_last;

  logic [N_W-1:0]   w_n_sh;
  logic [KEY_W-1:0] w_d_sh;
  logic [KEY_W-1:0] w_c_sh;
  logic [N_W-1:0]   w_n_full;

  logic [N_W-1:0]   r_n_o;
  logic [KEY_W-1:0] r_d_o;
  logic [KEY_W-1:0] r_c_o;
  logic [CNT_W-1:0] r_len_o;
  logic             r_valid;
  logic             r_err;

`ifdef SAM_CFG_PARITY_EN
  logic             w_par_err;
`else
  logic             r_pend;
  logic             w_pend_nxt;
`endif

  // Shadow registers for n, d and capsN
  sam_shift_reg #(.W(N_W)) u_n_sh (
    .clk   (clk),
    .rst_n (reset),
    .i_clr (w_clr),
    .i_en  (w_sh_n),
    .i_din (str),
    .o_q   (w_n_sh)
  );

  sam_shift_reg #(.W(KEY_W)) u_d_sh (
    .clk   (clk),
    .rst_n (reset),
    .i_clr (w_clr),
    .i_en  (w_sh_d),
    .i_din (str),
    .o_q   (w_d_sh)
  );

  sam_shift_reg #(.W(KEY_W)) u_c_sh (
    .clk   (clk),
    .rst_n (reset),
    .i_clr (w_clr),
    .i_en  (w_sh_c),
    .i_din (str),
    .o_q   (w_c_sh)
  );

  // n including the bit arriving this edge, used for the range check
  assign w_n_full  = N_W'({w_n_sh, str});
  assign w_n_ok    = (32'(w_n_full) <= LOG2_KEY);
  assign w_len_new = CNT_W'(sam_len_from_n(32'(w_n_full)));
  assign w_last    = (r_cnt == (r_len - CNT_W'(1)));

`ifdef SAM_CFG_PARITY_EN
  // Even parity across every shadow bit plus the received parity bit
  assign w_par_err = ^{w_n_sh, w_d_sh, w_c_sh, str};
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr       = 1'b0;
    w_sh_n      = 1'b0;
    w_sh_d      = 1'b0;
    w_sh_c      = 1'b0;
    w_len_load  = 1'b0;
    w_commit    = 1'b0;
    w_err_set   = 1'b0;
`ifndef SAM_CFG_PARITY_EN
    w_pend_nxt  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (mode) begin
          w_clr       = 1'b1;
          w_sh_n      = 1'b1;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = LOAD_N;
        end
      end
      LOAD_N: begin
        if (!mode) begin
          w_err_set   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_sh_n = 1'b1;
          if (r_cnt == N_LAST) begin
            w_cnt_nxt = '0;
            if (w_n_ok) begin
              w_len_load  = 1'b1;
              w_state_nxt = LOAD_D;
            end else begin
              w_err_set   = 1'b1;
              w_state_nxt = DONE;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      LOAD_D: begin
        if (!mode) begin
          w_err_set   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_sh_d = 1'b1;
          if (w_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = LOAD_CN;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      LOAD_CN: begin
        if (!mode) begin
          w_err_set   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_sh_c = 1'b1;
          if (w_last) begin
            w_cnt_nxt = '0;
`ifdef SAM_CFG_PARITY_EN
            w_state_nxt = CHECK;
`else
            w_pend_nxt  = 1'b1;
            w_state_nxt = DONE;
`endif
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
`ifdef SAM_CFG_PARITY_EN
      CHECK: begin
        if (!mode) begin
          w_err_set   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_commit    = !w_par_err;
          w_err_set   = w_par_err;
          w_state_nxt = DONE;
        end
      end
`endif
      DONE: begin
`ifndef SAM_CFG_PARITY_EN
        w_commit = r_pend;
`endif
        if (!mode) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Bit counter, key-length shadow and commit-pending flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_len  <= '0;
`ifndef SAM_CFG_PARITY_EN
      r_pend <= 1'b0;
`endif
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_clr) begin
        r_len <= '0;
      end else if (w_len_load) begin
        r_len <= w_len_new;
      end
`ifndef SAM_CFG_PARITY_EN
      r_pend <= w_pend_nxt;
`endif
    end
  end

  // Committed configuration; aborts only touch the error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_n_o   <= '0;
      r_d_o   <= '0;
      r_c_o   <= '0;
      r_len_o <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_commit) begin
      r_n_o   <= w_n_sh;
      r_d_o   <= w_d_sh;
      r_c_o   <= w_c_sh;
      r_len_o <= r_len;
      r_valid <= 1'b1;
      r_err   <= 1'b0;
    end else if (w_err_set) begin
      r_err   <= 1'b1;
    end
  end

  assign n_o       = r_n_o;
  assign d_o       = r_d_o;
  assign capsn_o   = r_c_o;
  assign key_len_o = r_len_o;
  assign cfg_valid = r_valid;
  assign cfg_err   = r_err;

endmodule
